mmio_bus: RTL and testbench

Memory-mapped I/O bus controller between the single-cycle CPU's data bus and the data memory / PDU. It decodes every CPU data access and either forwards it to data memory or services it from MMIO registers. The MMIO side provides an LED output register, a buffered output stream to the PDU (TX FIFO), and a one-word input mailbox from the PDU, each with a valid/ready handshake. An optional free-running cycle counter is also available.

---
 rtl/mmio_pkg.sv | 19 +
 rtl/mmio_fifo.sv | 50 +++++
 rtl/mmio_bus.sv | 124 ++++++++++++
 tb/tb_mmio_bus.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// Shared constants for the MMIO bus controller: base page, register offsets
// and status bit positions.
package mmio_pkg;

  localparam logic [23:0] MMIO_BASE     = 24'h00007F;

  localparam logic [7:0]  OFF_LED       = 8'h00;
  localparam logic [7:0]  OFF_TX_STATUS = 8'h04;
  localparam logic [7:0]  OFF_TX_DATA   = 8'h08;
  localparam logic [7:0]  OFF_IN_STATUS = 8'h0C;
  localparam logic [7:0]  OFF_IN_DATA   = 8'h10;
  localparam logic [7:0]  OFF_CYCLE     = 8'h14;

  localparam int TXS_NOT_FULL_BIT  = 0;
  localparam int TXS_OVERFLOW_BIT  = 1;
  localparam int TXS_COUNT_LSB     = 16;
  localparam int INS_VALID_BIT     = 0;

endpackage

// File: rtl/mmio_fifo.sv
// Synchronous FIFO with occupancy count; pushes while full and pops while
// empty are ignored, and the head reads as zero when empty.
module mmio_fifo #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  // Full is sampled before any same-cycle pop, so a pop never rescues a push.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/mmio_bus.sv
// CPU data-bus decoder: forwards to data memory or serves LED, TX FIFO and RX
// mailbox registers. Define MMIO_CYCLE_CNT_EN to add the cycle counter at 0x14.
module mmio_bus
  import mmio_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int LED_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      mem_addr,
  input  logic             mem_we,
  input  logic [31:0]      mem_din,
  output logic [31:0]      mem_dout,
  output logic [31:0]      dm_addr,
  output logic             dm_we,
  output logic [31:0]      dm_din,
  input  logic [31:0]      dm_dout,
  output logic [LED_W-1:0] led,
  output logic             out_valid,
  output logic [31:0]      out_data,
  input  logic             out_ready,
  input  logic             in_valid,
  input  logic [31:0]      in_data,
  output logic             in_ready
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic             is_mmio, wr;
  logic [7:0]       off;
  logic             tx_full, tx_empty;
  logic [CW-1:0]    tx_count;
  logic [LED_W-1:0] led_q, led_d;
  logic             ovf_q, ovf_d;
  logic             mbox_v_q, mbox_v_d;
  logic [31:0]      mbox_d_q, mbox_d_d;
  logic [31:0]      mmio_rdata;

  assign is_mmio = (mem_addr[31:8] == MMIO_BASE);
  assign off     = mem_addr[7:0];
  assign wr      = is_mmio & mem_we;

  assign dm_addr  = mem_addr;
  assign dm_din   = mem_din;
  assign dm_we    = mem_we & ~is_mmio;
  assign mem_dout = is_mmio ? mmio_rdata : dm_dout;

  mmio_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (wr && off == OFF_TX_DATA),
    .din_i   (mem_din),
    .pop_i   (out_ready),
    .dout_o  (out_data),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .count_o (tx_count)
  );

  assign out_valid = ~tx_empty;
  assign in_ready  = ~mbox_v_q;
  assign led       = led_q;

  always_comb begin
    led_d    = led_q;
    ovf_d    = ovf_q;
    mbox_v_d = mbox_v_q;
    mbox_d_d = mbox_d_q;
    if (wr && off == OFF_LED) led_d = mem_din[LED_W-1:0];
    if (wr && off == OFF_TX_STATUS)               ovf_d = 1'b0;
    else if (wr && off == OFF_TX_DATA && tx_full) ovf_d = 1'b1;
    // Acknowledge wins over a coincident offer; capture follows a cycle later.
    if (wr && off == OFF_IN_STATUS) begin
      mbox_v_d = 1'b0;
    end else if (in_valid && !mbox_v_q) begin
      mbox_v_d = 1'b1;
      mbox_d_d = in_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      led_q    <= '0;
      ovf_q    <= 1'b0;
      mbox_v_q <= 1'b0;
      mbox_d_q <= '0;
    end else begin
      led_q    <= led_d;
      ovf_q    <= ovf_d;
      mbox_v_q <= mbox_v_d;
      mbox_d_q <= mbox_d_d;
    end
  end

`ifdef MMIO_CYCLE_CNT_EN
  logic [31:0] cyc_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                          cyc_q <= '0;
    else if (wr && off == OFF_CYCLE)   cyc_q <= mem_din;
    else                               cyc_q <= cyc_q + 32'd1;
  end
`endif

  always_comb begin
    mmio_rdata = '0;
    case (off)
      OFF_LED:       mmio_rdata = 32'(led_q);
      OFF_TX_STATUS: begin
        mmio_rdata[TXS_NOT_FULL_BIT] = ~tx_full;
        mmio_rdata[TXS_OVERFLOW_BIT] = ovf_q;
        mmio_rdata[TXS_COUNT_LSB +: 16] = 16'(tx_count);
      end
      OFF_IN_STATUS: mmio_rdata[INS_VALID_BIT] = mbox_v_q;
      OFF_IN_DATA:   mmio_rdata = mbox_d_q;
`ifdef MMIO_CYCLE_CNT_EN
      OFF_CYCLE:     mmio_rdata = cyc_q;
`endif
      default:       mmio_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_mmio_bus.sv
// Randomised scoreboard bench for mmio_bus with a queue-based reference model.
module tb_mmio_bus;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_addr, mem_din, mem_dout, dm_addr, dm_din, dm_dout;
  logic        mem_we, dm_we;
  logic [15:0] led;
  logic        out_valid, out_ready, in_valid, in_ready;
  logic [31:0] out_data, in_data;

  mmio_bus #(.FIFO_DEPTH(8), .LED_W(16)) dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_we(mem_we), .mem_din(mem_din),
    .mem_dout(mem_dout), .dm_addr(dm_addr), .dm_we(dm_we), .dm_din(dm_din),
    .dm_dout(dm_dout), .led(led), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] dout; logic dm_we; logic [31:0] addr; logic [31:0] din; } exp_t;

  int          tests = 0, fails = 0;
  bit          active = 0;
  exp_t        eq[$];
  logic [31:0] mq[$];
  logic [31:0] sb[$];
  logic [15:0] m_led;
  bit          m_ovf, m_mv;
  logic [31:0] m_md, m_cyc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void m_reset();
    mq.delete(); sb.delete(); eq.delete();
    m_led = 0; m_ovf = 0; m_mv = 0; m_md = 0; m_cyc = 0;
  endfunction

  function automatic logic [31:0] m_read(input logic [7:0] off);
    case (off)
      8'h00: return {16'h0, m_led};
      8'h04: return {16'(mq.size()), 14'h0, m_ovf, 1'(mq.size() < 8)};
      8'h0C: return {31'h0, m_mv};
      8'h10: return m_md;
`ifdef MMIO_CYCLE_CNT_EN
      8'h14: return m_cyc;
`endif
      default: return 32'h0;
    endcase
  endfunction

  // One CPU cycle: drive, predict, let the edge pass, advance the model.
  task automatic cpu_op(input logic [31:0] addr, input bit we, input logic [31:0] din,
                        input bit ordy, input bit iv, input logic [31:0] idata,
                        input bit dchk = 0, input logic [31:0] dexp = 0, input string dname = "");
    exp_t e;
    bit   mm, w, pre_full, pre_mv;
    mem_addr = addr; mem_we = we; mem_din = din; dm_dout = $urandom;
    out_ready = ordy; in_valid = iv; in_data = idata;
    mm = (addr[31:8] == 24'h00007F);
    e.dout = mm ? m_read(addr[7:0]) : dm_dout;
    e.dm_we = we && !mm;
    e.addr = addr; e.din = din;
    eq.push_back(e);
    active = 1;
    if (dchk) begin
      #1;
      chk(dname, we ? {31'h0, dm_we} : mem_dout, dexp);
    end
    @(posedge clk);
    w = mm && we;
    pre_full = (mq.size() == 8);
    pre_mv = m_mv;
    if (ordy && mq.size() > 0) void'(mq.pop_front());
    if (w && addr[7:0] == 8'h08) begin
      if (pre_full) m_ovf = 1;
      else begin mq.push_back(din); sb.push_back(din); end
    end
    if (w && addr[7:0] == 8'h04) m_ovf = 0;
    if (w && addr[7:0] == 8'h00) m_led = din[15:0];
    if (w && addr[7:0] == 8'h0C) m_mv = 0;
    else if (iv && !pre_mv) begin m_mv = 1; m_md = idata; end
`ifdef MMIO_CYCLE_CNT_EN
    if (w && addr[7:0] == 8'h14) m_cyc = din; else m_cyc = m_cyc + 1;
`endif
    #1;
  endtask

  task automatic nop(input bit ordy, input bit iv = 0, input logic [31:0] idata = 0);
    cpu_op(32'h0000_0100, 0, 0, ordy, iv, idata);
  endtask

  // Monitor: compares every presented output against the scoreboard queues.
  always @(negedge clk) begin
    if (active && rst) begin
      if (eq.size() > 0) begin
        exp_t e;
        e = eq.pop_front();
        chk("mem_dout", mem_dout, e.dout);
        chk("dm_we", {31'h0, dm_we}, {31'h0, e.dm_we});
        chk("dm_addr", dm_addr, e.addr);
        chk("dm_din", dm_din, e.din);
      end
      chk("out_valid", {31'h0, out_valid}, {31'h0, sb.size() != 0});
      chk("in_ready", {31'h0, in_ready}, {31'h0, !m_mv});
      if (!out_valid) chk("out_data_idle", out_data, 32'h0);
      else if (out_ready) begin
        if (sb.size() == 0) begin
          tests++; fails++;
          $display("FAIL tx_pop: got 0x%08h expected no word at %0t", out_data, $time);
        end else chk("out_data", out_data, sb.pop_front());
      end
    end
  end

  initial begin
    logic [31:0] a, cyc_exp;
    rst = 0; mem_addr = 0; mem_we = 0; mem_din = 0; dm_dout = 0;
    out_ready = 0; in_valid = 0; in_data = 0;
    m_reset();
    #12;
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
    chk("rst_led", {16'h0, led}, 32'h0);
    chk("rst_out_data", out_data, 32'h0);
    @(posedge clk); #1; rst = 1;

    cpu_op(32'h7F00, 1, 32'hA5, 0, 0, 0);
    cpu_op(32'h7F00, 0, 0, 0, 0, 0, 1, 32'hA5, "led_read");
    chk("led_port", {16'h0, led}, 32'h00A5);
    cpu_op(32'h0000_0010, 1, 32'h1234, 0, 0, 0, 1, 32'h1, "dm_we_mem");
    cpu_op(32'h7F00, 1, 32'h55, 0, 0, 0, 1, 32'h0, "dm_we_mmio");

    for (int i = 1; i <= 8; i++) cpu_op(32'h7F08, 1, i, 0, 0, 0);
    cpu_op(32'h7F04, 0, 0, 0, 0, 0, 1, 32'h0008_0000, "tx_full_status");
    cpu_op(32'h7F08, 1, 9, 0, 0, 0);
    cpu_op(32'h7F04, 0, 0, 0, 0, 0, 1, 32'h0008_0002, "tx_overflow");
    for (int i = 0; i < 8; i++) nop(1);
    chk("tx_drained", {31'h0, out_valid}, 32'h0);
    cpu_op(32'h7F04, 1, 0, 0, 0, 0);
    cpu_op(32'h7F04, 0, 0, 0, 0, 0, 1, 32'h0000_0001, "ovf_clear");

    nop(0, 1, 32'hDEADBEEF);
    chk("in_ready_fell", {31'h0, in_ready}, 32'h0);
    cpu_op(32'h7F0C, 0, 0, 0, 0, 0, 1, 32'h1, "in_status");
    cpu_op(32'h7F10, 0, 0, 0, 1, 32'h12345678, 1, 32'hDEADBEEF, "in_data");
    cpu_op(32'h7F10, 0, 0, 0, 1, 32'h12345678, 1, 32'hDEADBEEF, "in_held_off");
    cpu_op(32'h7F0C, 1, 0, 0, 1, 32'h12345678);
    cpu_op(32'h7F0C, 0, 0, 0, 1, 32'h12345678, 1, 32'h0, "ack_cleared");
    cpu_op(32'h7F10, 0, 0, 0, 0, 0, 1, 32'h12345678, "in_second");

    cpu_op(32'h7F14, 1, 32'hFFFF_FFFE, 0, 0, 0);
    nop(0); nop(0); nop(0);
`ifdef MMIO_CYCLE_CNT_EN
    cyc_exp = 32'h1;
`else
    cyc_exp = 32'h0;
`endif
    cpu_op(32'h7F14, 0, 0, 0, 0, 0, 1, cyc_exp, "cycle_cnt");

    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5, 6: a = 32'h7F00 | (32'($urandom_range(0, 5)) << 2);
        7:       a = 32'h7F00 | (32'($urandom_range(6, 63)) << 2);
        default: begin
          a = $urandom;
          if (a[31:8] == 24'h00007F) a[8] = ~a[8];
        end
      endcase
      cpu_op(a, 1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 3) == 0,
             $urandom_range(0, 2) == 0, $urandom);
    end

    for (int i = 0; i < 10; i++) nop(1);
    cpu_op(32'h7F0C, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cpu_op(32'h7F08, 1, 32'hA0 + i, 0, 0, 0);
    cpu_op(32'h7F00, 1, 32'hBEEF, 0, 1, 32'hCAFEF00D);
    cpu_op(32'h7F04, 0, 0, 0, 0, 0, 1, 32'h0003_0001, "pre_rst_status");
    active = 0;
    in_valid = 0;
    #2 rst = 0;
    #1;
    chk("mid_rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("mid_rst_in_ready", {31'h0, in_ready}, 32'h1);
    chk("mid_rst_led", {16'h0, led}, 32'h0);
    chk("mid_rst_out_data", out_data, 32'h0);
    m_reset();
    @(posedge clk); #1; rst = 1;
    cpu_op(32'h7F04, 0, 0, 1, 0, 0, 1, 32'h0000_0001, "post_rst_status");
    cpu_op(32'h7F10, 0, 0, 1, 0, 0, 1, 32'h0, "post_rst_mbox");
    for (int i = 0; i < 100; i++)
      cpu_op(32'h7F00 | (32'($urandom_range(0, 5)) << 2), 1'($urandom_range(0, 1)),
             $urandom, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom);
    active = 0;
    #20;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
